// File: rtl/if_id_reg_pkg.sv
// Shared definitions for the fetch/decode pipeline register.
package if_id_reg_pkg;

    // Default datapath width of the instruction and pc fields
    localparam int XLEN_DEFAULT = 32;

    // Canonical nop (addi x0, x0, 0) inserted on reset and flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // All-zero value used for cleared pc fields
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Occupancy of the register; the valid output is this state
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fill_state_e;

endpackage

// File: rtl/if_id_reg_sat_counter.sv
// Saturating up-counter used for the fetch/decode performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Advance by one when asked, but stick at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    // Register the count with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch outputs, applies stall and flush,
// tracks occupancy and keeps saturating fetched/killed/stalled counters.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  instr_if_o,
    input  logic [XLEN-1:0]  pc_if_o,
    input  logic [XLEN-1:0]  pc_add_4_if_o,
    input  logic [XLEN-1:0]  pc_add_imme_if_o,
    input  logic [XLEN-1:0]  jalr_pc_prediction_or_pc_if_o,
    input  logic             B_type_prediction_result_if_o,
    input  logic             fetch_bubble,
    input  logic             PL_stall,
    input  logic             PL_flush,
    output logic [XLEN-1:0]  instr_if_id_o,
    output logic [XLEN-1:0]  pc_if_id_o,
    output logic [XLEN-1:0]  pc_add_4_if_id_o,
    output logic [XLEN-1:0]  pc_add_imme_if_id_o,
    output logic [XLEN-1:0]  jalr_pc_prediction_or_pc_if_id_o,
    output logic             B_type_prediction_result_if_id_o,
    output logic             valid_if_id_o,
    output logic [CNT_W-1:0] cnt_fetched,
    output logic [CNT_W-1:0] cnt_killed,
    output logic [CNT_W-1:0] cnt_stalled
);

    localparam logic [XLEN-1:0] NOP_X  = XLEN'(NOP_INSTR);
    localparam logic [XLEN-1:0] ZERO_X = XLEN'(ZERO_WORD);

    logic [XLEN-1:0] instr_d,    instr_q;
    logic [XLEN-1:0] pc_d,       pc_q;
    logic [XLEN-1:0] pc_add_4_d, pc_add_4_q;
    logic [XLEN-1:0] pc_imme_d,  pc_imme_q;
    logic [XLEN-1:0] jalr_pc_d,  jalr_pc_q;
    logic            b_pred_d,   b_pred_q;
    fill_state_e     state_d,    state_q;

    logic inc_fetched;
    logic inc_killed;
    logic inc_stalled;

    // Next-state selection: flush beats stall, stall beats a normal load
    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        pc_add_4_d  = pc_add_4_q;
        pc_imme_d   = pc_imme_q;
        jalr_pc_d   = jalr_pc_q;
        b_pred_d    = b_pred_q;
        state_d     = state_q;
        inc_fetched = 1'b0;
        inc_killed  = 1'b0;
        inc_stalled = 1'b0;
        if (PL_flush) begin
            instr_d    = NOP_X;
            pc_d       = ZERO_X;
            pc_add_4_d = ZERO_X;
            pc_imme_d  = ZERO_X;
            jalr_pc_d  = ZERO_X;
            b_pred_d   = 1'b0;
            state_d    = ST_EMPTY;
            inc_killed = (state_q == ST_FULL);
        end else if (PL_stall) begin
            inc_stalled = 1'b1;
        end else begin
            instr_d     = instr_if_o;
            pc_d        = pc_if_o;
            pc_add_4_d  = pc_add_4_if_o;
            pc_imme_d   = pc_add_imme_if_o;
            jalr_pc_d   = jalr_pc_prediction_or_pc_if_o;
            b_pred_d    = B_type_prediction_result_if_o && !fetch_bubble;
            state_d     = fetch_bubble ? ST_EMPTY : ST_FULL;
            inc_fetched = !fetch_bubble;
        end
    end

    // Pipeline fields and occupancy state, cleared to a nop bubble on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q    <= NOP_X;
            pc_q       <= ZERO_X;
            pc_add_4_q <= ZERO_X;
            pc_imme_q  <= ZERO_X;
            jalr_pc_q  <= ZERO_X;
            b_pred_q   <= 1'b0;
            state_q    <= ST_EMPTY;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_add_4_q <= pc_add_4_d;
            pc_imme_q  <= pc_imme_d;
            jalr_pc_q  <= jalr_pc_d;
            b_pred_q   <= b_pred_d;
            state_q    <= state_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_fetched (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_fetched),
        .count (cnt_fetched)
    );

    sat_counter #(.W(CNT_W)) u_cnt_killed (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_killed),
        .count (cnt_killed)
    );

    sat_counter #(.W(CNT_W)) u_cnt_stalled (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_stalled),
        .count (cnt_stalled)
    );

    assign instr_if_id_o                    = instr_q;
    assign pc_if_id_o                       = pc_q;
    assign pc_add_4_if_id_o                 = pc_add_4_q;
    assign pc_add_imme_if_id_o              = pc_imme_q;
    assign jalr_pc_prediction_or_pc_if_id_o = jalr_pc_q;
    assign B_type_prediction_result_if_id_o = b_pred_q;
    assign valid_if_id_o                    = (state_q == ST_FULL);

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg; narrow counters make saturation reachable.
module tb_if_id_reg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [XLEN-1:0]  instr;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  pc4;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  jalr;
      logic             bPred;
      logic             valid;
      logic [CNT_W-1:0] fetched;
      logic [CNT_W-1:0] killed;
      logic [CNT_W-1:0] stalled;
   } expect_t;

   logic             clk;
   logic             rst_n;
   logic [XLEN-1:0]  instrIn, pcIn, pc4In, immIn, jalrIn;
   logic             bIn, bubbleIn, stallIn, flushIn;
   logic [XLEN-1:0]  instrOut, pcOut, pc4Out, immOut, jalrOut;
   logic             bOut, validOut;
   logic [CNT_W-1:0] cntFetched, cntKilled, cntStalled;

   expect_t model;
   expect_t scoreboard[$];
   int errorCount = 0;
   int checkCount = 0;

   if_id_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk                              (clk),
      .rst_n                            (rst_n),
      .instr_if_o                       (instrIn),
      .pc_if_o                          (pcIn),
      .pc_add_4_if_o                    (pc4In),
      .pc_add_imme_if_o                 (immIn),
      .jalr_pc_prediction_or_pc_if_o    (jalrIn),
      .B_type_prediction_result_if_o    (bIn),
      .fetch_bubble                     (bubbleIn),
      .PL_stall                         (stallIn),
      .PL_flush                         (flushIn),
      .instr_if_id_o                    (instrOut),
      .pc_if_id_o                       (pcOut),
      .pc_add_4_if_id_o                 (pc4Out),
      .pc_add_imme_if_id_o              (immOut),
      .jalr_pc_prediction_or_pc_if_id_o (jalrOut),
      .B_type_prediction_result_if_id_o (bOut),
      .valid_if_id_o                    (validOut),
      .cnt_fetched                      (cntFetched),
      .cnt_killed                       (cntKilled),
      .cnt_stalled                      (cntStalled)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation and log a mismatch
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Saturating increment of a model counter
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 4'd1;
   endfunction

   // Drive one cycle of inputs, predict the result, clock it and compare
   task automatic applyStimulus(input logic rstN, input logic [31:0] instr, input logic [31:0] pc,
                                input logic bPred, input logic bubble, input logic stall, input logic flush);
      expect_t got;
      expect_t exp;
      rst_n    = rstN;
      instrIn  = instr;
      pcIn     = pc;
      pc4In    = pc + 32'd4;
      immIn    = pc + 32'h40;
      jalrIn   = pc ^ 32'h0000_8000;
      bIn      = bPred;
      bubbleIn = bubble;
      stallIn  = stall;
      flushIn  = flush;
      if (!rstN) begin
         model = '{NOP, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0};
      end else if (flush) begin
         if (model.valid) model.killed = satInc(model.killed);
         model.instr = NOP;
         model.pc = 0; model.pc4 = 0; model.imm = 0; model.jalr = 0;
         model.bPred = 1'b0;
         model.valid = 1'b0;
      end else if (stall) begin
         model.stalled = satInc(model.stalled);
      end else begin
         model.instr = instr;
         model.pc    = pc;
         model.pc4   = pc + 32'd4;
         model.imm   = pc + 32'h40;
         model.jalr  = pc ^ 32'h0000_8000;
         model.bPred = bubble ? 1'b0 : bPred;
         model.valid = !bubble;
         if (!bubble) model.fetched = satInc(model.fetched);
      end
      scoreboard.push_back(model);
      @(posedge clk);
      #1;
      if (scoreboard.size() == 0) begin
         checkOutput("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         exp = scoreboard.pop_front();
         got = '{instrOut, pcOut, pc4Out, immOut, jalrOut, bOut, validOut, cntFetched, cntKilled, cntStalled};
         checkOutput("instr",   64'(got.instr),   64'(exp.instr));
         checkOutput("pc",      64'(got.pc),      64'(exp.pc));
         checkOutput("pc4",     64'(got.pc4),     64'(exp.pc4));
         checkOutput("pcImm",   64'(got.imm),     64'(exp.imm));
         checkOutput("jalrPc",  64'(got.jalr),    64'(exp.jalr));
         checkOutput("bPred",   64'(got.bPred),   64'(exp.bPred));
         checkOutput("valid",   64'(got.valid),   64'(exp.valid));
         checkOutput("fetched", 64'(got.fetched), 64'(exp.fetched));
         checkOutput("killed",  64'(got.killed),  64'(exp.killed));
         checkOutput("stalled", 64'(got.stalled), 64'(exp.stalled));
      end
   endtask

   // Directed scenarios followed by a short randomized run
   initial begin
      model = '{NOP, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0};
      // Reset held two cycles, then a first valid load
      applyStimulus(1'b0, 32'h0050_0093, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0050_0093, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
      // Load then stall three cycles while fetch moves on
      applyStimulus(1'b1, 32'h00a0_0113, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 32'h0010_0193, 32'h108, 1'b0, 1'b0, 1'b1, 1'b0);
      // Flush and stall together on a valid entry
      applyStimulus(1'b1, 32'h0020_0213, 32'h10c, 1'b1, 1'b0, 1'b1, 1'b1);
      // Flush of an empty register must not count as a kill
      applyStimulus(1'b1, 32'h0020_0213, 32'h10c, 1'b1, 1'b0, 1'b0, 1'b1);
      // Bubble with a prediction attached
      applyStimulus(1'b1, NOP, 32'h110, 1'b1, 1'b1, 1'b0, 1'b0);
      // Valid load then bubble turns a full register empty
      applyStimulus(1'b1, 32'h0030_0293, 32'h114, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, NOP, 32'h118, 1'b0, 1'b1, 1'b0, 1'b0);
      // Enough loads to drive the fetched counter into saturation
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, 32'h0000_0093 + (i << 20), 32'h200 + i * 4, i[0], 1'b0, 1'b0, 1'b0);
      // Enough stalls to saturate the stalled counter
      for (int i = 0; i < 14; i++)
         applyStimulus(1'b1, 32'hdead_beef, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0);
      // Reset asserted mid-stall with a valid entry
      applyStimulus(1'b0, 32'h0040_0313, 32'h400, 1'b1, 1'b0, 1'b1, 1'b0);
      // Randomized mix of loads, bubbles, stalls, flushes and rare resets
      for (int i = 0; i < 80; i++)
         applyStimulus(($urandom_range(0, 29) != 0), $urandom, $urandom,
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
